// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and helpers for the bit-serial subtractor sequencer.
//   state_t     : FSM state encoding (IDLE, RUN, DONE), 2 bits.
//   cnt_width() : width of the bit counter for a given operand width.
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    // Clamped to 1 so a degenerate width still yields a legal vector.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_sub.sv
// -----------------------------------------------------------------------------
// sub
// Existing 1-bit full-subtractor cell: computes a - b - cin.
// Ports:
//   a, b  : operand bits
//   cin   : borrow in
//   s     : difference bit
//   cout  : borrow out
// -----------------------------------------------------------------------------
module sub (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (~a & b) | (~(a ^ b) & cin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
// Multi-cycle WIDTH-bit subtractor (A - B - bin) built by running the 1-bit
// `sub` cell once per clock, LSB first, with the borrow kept in a register.
//
// Handshake: start is sampled only in IDLE. An accepted start captures
// a_in/b_in/bin; busy is high for the WIDTH shifting cycles (RUN); done pulses
// for exactly one cycle (DONE) when diff/bout are valid. Starts seen in RUN or
// DONE are dropped. diff/bout then hold until the next accepted start.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : request pulse
//   a_in, b_in : minuend / subtrahend (WIDTH bits)
//   bin        : initial borrow into bit 0
//   diff       : result modulo 2^WIDTH
//   bout       : borrow out of the MSB
//   busy       : high in RUN
//   done       : one-cycle result-valid pulse
//   ovf        : signed overflow (only when SERIAL_SUB_OVF_EN is defined)
//   dbg_state  : current FSM state, for observation only
//
// Build option: define SERIAL_SUB_OVF_EN to add the ovf port and its logic.
// -----------------------------------------------------------------------------
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic             borrow_q;
    logic             cell_s, cell_cout;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    sub u_sub (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (borrow_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand shifters, result shifter, borrow and bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr     <= a_in;
                        b_sr     <= b_in;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    // Bits arrive LSB first, so each new bit enters at the
                    // MSB; after WIDTH shifts bit 0 sits at position 0.
                    diff_sr  <= {cell_s, diff_sr[WIDTH-1:1]};
                    borrow_q <= cell_cout;
                    a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
                    if (!last_bit) cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept separately because the shifters consume them.
    logic [1:0] msb_q;
    logic       ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msb_q <= 2'b00;
            ovf_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                msb_q <= {a_in[WIDTH-1], b_in[WIDTH-1]};
                ovf_q <= 1'b0;
            end else if (state_q == RUN && last_bit) begin
                // On the final shift the cell output is the result MSB.
                ovf_q <= (msb_q[1] ^ msb_q[0]) & (msb_q[1] ^ cell_s);
            end
        end
    end

    assign ovf = ovf_q;
`endif

    assign diff      = diff_sr;
    assign bout      = borrow_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_ctrl
// Self-checking bench for serial_sub_ctrl (WIDTH=8). Expected results come from
// integer arithmetic on the operands. Handshake contract exercised:
// start is honoured only when the block is idle; done pulses once, WIDTH
// edges after the accepting edge; busy spans exactly the WIDTH shift cycles.
// -----------------------------------------------------------------------------
module tb_serial_sub_ctrl;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout, busy, done;
    logic [1:0]   dbg_state;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .bin       (bin),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy),
        .done      (done),
`ifdef SERIAL_SUB_OVF_EN
        .ovf       (ovf),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] a, b, input logic bi);
        int r;
        r = int'(a) - int'(b) - int'(bi);
        return W'(r);
    endfunction

    function automatic logic model_bout(input logic [W-1:0] a, b, input logic bi);
        return int'(a) < (int'(b) + int'(bi));
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, b, input logic bi);
        int sa, sb, r;
        sa = (int'(a) >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
        sb = (int'(b) >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
        r  = sa - sb - int'(bi);
        return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endfunction

    // ---------------- driver ----------------
    // Issues one start and watches a fixed window afterwards. done_at is the
    // number of edges after the accepting edge at which done was first seen.
    // inj_cycle >= 0 re-pulses start (with a_in all ones) at that RUN cycle.
    task automatic run_op(input logic [W-1:0] a, b, input logic bi, input int inj_cycle,
                          output int done_at, output int busy_cnt, output int done_cnt,
                          output logic [W-1:0] d, output logic bo, output logic ov);
        done_at  = -1;
        busy_cnt = 0;
        done_cnt = 0;
        d        = '0;
        bo       = 1'b0;
        ov       = 1'b0;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        bin   = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // operands are free to change once accepted
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        bin   = 1'($urandom);
        for (int j = 0; j < W + 6; j++) begin
            if (j == inj_cycle) begin
                start = 1'b1;
                a_in  = '1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = j;
                    d       = diff;
                    bo      = bout;
`ifdef SERIAL_SUB_OVF_EN
                    ov      = ovf;
`endif
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (diff !== '0) begin failures++; $display("FAIL reset_diff got=%h want=00", diff); end
        checks++;
        if (bout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_flags got bout=%b busy=%b done=%b want 0/0/0", bout, busy, done);
        end
        checks++;
        if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int da, bc, dc; logic [W-1:0] d; logic bo, ov;
        run_op(8'h05, 8'h03, 1'b0, -1, da, bc, dc, d, bo, ov);
        checks++;
        if (da != W) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", da, W); end
        checks++;
        if (bc != W) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, W); end
        checks++;
        if (dc != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d want=1", dc); end
        checks++;
        if (d !== 8'h02 || bo !== 1'b0) begin
            failures++; $display("FAIL basic_result got=%h/%b want=02/0", d, bo);
        end
    endtask

    task automatic test_borrow_hold();
        int da, bc, dc; logic [W-1:0] d; logic bo, ov;
        run_op(8'h03, 8'h05, 1'b0, -1, da, bc, dc, d, bo, ov);
        checks++;
        if (d !== 8'hFE || bo !== 1'b1) begin
            failures++; $display("FAIL borrow_result got=%h/%b want=fe/1", d, bo);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (diff !== 8'hFE || bout !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL hold_idle got=%h/%b busy=%b want=fe/1 busy=0", diff, bout, busy);
        end
    endtask

    task automatic test_bin();
        int da, bc, dc; logic [W-1:0] d; logic bo, ov;
        run_op(8'h10, 8'h00, 1'b1, -1, da, bc, dc, d, bo, ov);
        checks++;
        if (d !== 8'h0F || bo !== 1'b0) begin
            failures++; $display("FAIL bin_10 got=%h/%b want=0f/0", d, bo);
        end
        run_op(8'h00, 8'h00, 1'b1, -1, da, bc, dc, d, bo, ov);
        checks++;
        if (d !== 8'hFF || bo !== 1'b1) begin
            failures++; $display("FAIL bin_00 got=%h/%b want=ff/1", d, bo);
        end
    endtask

    task automatic test_start_ignored();
        int da, bc, dc; logic [W-1:0] d; logic bo, ov;
        run_op(8'h09, 8'h04, 1'b0, 3, da, bc, dc, d, bo, ov);
        checks++;
        if (d !== 8'h05 || bo !== 1'b0) begin
            failures++; $display("FAIL ignore_result got=%h/%b want=05/0", d, bo);
        end
        checks++;
        if (dc != 1 || da != W) begin
            failures++; $display("FAIL ignore_done got pulses=%0d at=%0d want 1 at %0d", dc, da, W);
        end
    endtask

    task automatic test_reset_mid();
        int da, bc, dc, seen; logic [W-1:0] d; logic bo, ov;
        @(negedge clk);
        a_in  = 8'h55;
        b_in  = 8'h11;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (diff !== '0 || busy !== 1'b0 || done !== 1'b0 || bout !== 1'b0) begin
            failures++; $display("FAIL midreset_clear got diff=%h bout=%b busy=%b done=%b want 00/0/0/0",
                                 diff, bout, busy, done);
        end
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        for (int j = 0; j < W + 4; j++) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midreset_quiet got active_cycles=%0d want=0", seen); end
        run_op(8'h20, 8'h01, 1'b0, -1, da, bc, dc, d, bo, ov);
        checks++;
        if (d !== 8'h1F || bo !== 1'b0 || da != W) begin
            failures++; $display("FAIL midreset_fresh got=%h/%b at=%0d want=1f/0 at %0d", d, bo, da, W);
        end
    endtask

    task automatic test_random();
        int da, bc, dc; logic [W-1:0] d; logic bo, ov;
        logic [W-1:0] a, b; logic bi;
        for (int n = 0; n < 24; n++) begin
            a  = W'($urandom_range(0, (1 << W) - 1));
            b  = W'($urandom_range(0, (1 << W) - 1));
            bi = 1'($urandom_range(0, 1));
            run_op(a, b, bi, -1, da, bc, dc, d, bo, ov);
            checks++;
            if (d !== model_diff(a, b, bi) || bo !== model_bout(a, b, bi)) begin
                failures++; $display("FAIL rand_result a=%h b=%h bin=%b got=%h/%b want=%h/%b",
                                     a, b, bi, d, bo, model_diff(a, b, bi), model_bout(a, b, bi));
            end
            checks++;
            if (da != W || bc != W || dc != 1) begin
                failures++; $display("FAIL rand_timing got at=%0d busy=%0d pulses=%0d want %0d/%0d/1",
                                     da, bc, dc, W, W);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ov !== model_ovf(a, b, bi)) begin
                failures++; $display("FAIL rand_ovf a=%h b=%h bin=%b got=%b want=%b",
                                     a, b, bi, ov, model_ovf(a, b, bi));
            end
`endif
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        int da, bc, dc; logic [W-1:0] d; logic bo, ov;
        run_op(8'h80, 8'h01, 1'b0, -1, da, bc, dc, d, bo, ov);
        checks++;
        if (d !== 8'h7F || ov !== 1'b1) begin
            failures++; $display("FAIL ovf_80 got=%h ovf=%b want=7f ovf=1", d, ov);
        end
        checks++;
        if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_hold got=%b want=1", ovf); end
        run_op(8'h7F, 8'h01, 1'b0, -1, da, bc, dc, d, bo, ov);
        checks++;
        if (d !== 8'h7E || ov !== 1'b0) begin
            failures++; $display("FAIL ovf_7f got=%h ovf=%b want=7e ovf=0", d, ov);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_borrow_hold();
        test_bin();
        test_start_ignored();
        test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
